// File: rtl/inst_fetch.sv
// inst_fetch: single-stage instruction fetch with stall replay, redirect flush and halt at END_PC
module inst_fetch #(
  parameter logic [7:0] START_PC = 8'd0,
  parameter logic [7:0] END_PC   = 8'd113
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  mem_address,
  input  logic [31:0] mem_data,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted
);
  typedef enum logic {RUN, HALT} state_t;
  state_t     r_state;
  logic [7:0] r_pc_q;
  logic [7:0] r_pc_d1;
  logic       r_issued_d1;
  logic       w_at_end;
  // while stalled, re-present last cycle's address so the word arrives again on release
  assign mem_address = rst ? START_PC : (stall && !redirect_valid) ? r_pc_d1 : r_pc_q;
  assign halted      = (r_state == HALT) && !r_issued_d1 && !instr_valid;
  assign w_at_end    = r_pc_q == END_PC;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_q      <= START_PC;
      r_pc_d1     <= 8'd0;
      r_issued_d1 <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 8'd0;
      instr_valid <= 1'b0;
      r_state     <= RUN;
    end else if (redirect_valid) begin
      r_pc_q      <= redirect_pc;
      r_issued_d1 <= 1'b0;
      instr_valid <= 1'b0;
      r_state     <= RUN;
    end else if (!stall) begin
      instr       <= mem_data;
      instr_pc    <= r_pc_d1;
      instr_valid <= r_issued_d1;
      if (r_state == RUN) begin
        r_pc_d1     <= r_pc_q;
        r_issued_d1 <= 1'b1;
        r_pc_q      <= w_at_end ? r_pc_q : r_pc_q + 8'd1;
        r_state     <= w_at_end ? HALT : RUN;
      end else begin
        r_issued_d1 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed stimulus with a scoreboard of expected fetch addresses
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic [7:0]  mem_address, mem_address2;
  logic [31:0] mem_data = 32'd0, mem_data2 = 32'd0;
  logic [31:0] instr, instr2;
  logic [7:0]  instr_pc, instr_pc2;
  logic        instr_valid, instr_valid2, halted, halted2;
  logic [7:0]  q[$];
  logic        ld_prev = 1'b0;
  logic [31:0] saved;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  inst_fetch u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_address(mem_address), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
  );

  inst_fetch #(.START_PC(8'd254), .END_PC(8'd255)) u_dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(8'd0), .mem_address(mem_address2), .mem_data(mem_data2),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .halted(halted2)
  );

  function automatic logic [31:0] rom(input logic [7:0] a);
    return {a ^ 8'h5A, ~a, a + 8'd17, a};
  endfunction

  always @(posedge clk) begin
    mem_data  <= rom(mem_address);
    mem_data2 <= rom(mem_address2);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // IF/ID loads only after a cycle with no reset, stall or redirect
  always @(negedge clk) begin
    if (ld_prev && instr_valid) begin
      if (q.size() == 0) chk("sb_unexpected_instr", q.size(), 1);
      else begin
        automatic logic [7:0] e = q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, rom(e));
      end
    end
    ld_prev <= !rst && !stall && !redirect_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic push_range(input int lo, input int n);
    for (int i = 0; i < n; i++) q.push_back(8'(lo + i));
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd77;
    tick();
    tick();
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_address2", mem_address2, 254);
    tick();
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to_halt();
    int k = 0;
    while (!halted && k < 400) begin
      tick();
      k++;
    end
    #1;
    chk("halt_reached", halted, 1);
    repeat (3) tick();
    chk("sb_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    do_reset();
    push_range(0, 114);
    #1;
    chk("c0_mem_address", mem_address, 0);
    go_to(1);
    chk("c1_valid", instr_valid, 0);
    go_to(2);
    chk("c2_valid", instr_valid, 1);
    chk("c2_pc", instr_pc, 0);
    chk("d2_c2_pc", instr_pc2, 254);
    chk("d2_c2_valid", instr_valid2, 1);
    go_to(3);
    chk("d2_c3_pc", instr_pc2, 255);
    chk("d2_c3_valid", instr_valid2, 1);
    go_to(4);
    chk("d2_c4_valid", instr_valid2, 0);
    chk("d2_c4_halted", halted2, 1);
    chk("d2_c4_mem_address", mem_address2, 255);
    go_to(115);
    chk("c115_pc", instr_pc, 113);
    chk("c115_halted", halted, 0);
    go_to(116);
    chk("c116_valid", instr_valid, 0);
    chk("c116_halted", halted, 1);
    chk("c116_mem_address", mem_address, 113);
    go_to(120);
    chk("c120_halted", halted, 1);
    chk("c120_mem_address", mem_address, 113);
    run_to_halt();

    do_reset();
    push_range(0, 6);
    go_to(5);
    stall = 1'b1;
    #1;
    chk("stall_c5_pc", instr_pc, 3);
    chk("stall_mem_address", mem_address, 4);
    saved = instr;
    for (int c = 6; c <= 8; c++) begin
      go_to(c);
      if (c == 8) stall = 1'b0;
      #1;
      chk("stall_hold_pc", instr_pc, 3);
      chk("stall_hold_instr", instr, saved);
    end
    go_to(9);
    chk("stall_c9_pc", instr_pc, 4);
    go_to(10);
    redirect_valid = 1'b1; redirect_pc = 8'd40;
    push_range(40, 74);
    go_to(11);
    redirect_valid = 1'b0;
    chk("redir_c11_valid", instr_valid, 0);
    go_to(12);
    chk("redir_c12_valid", instr_valid, 0);
    go_to(13);
    chk("redir_c13_valid", instr_valid, 1);
    chk("redir_c13_pc", instr_pc, 40);
    chk("redir_c13_instr", instr, rom(8'd40));
    go_to(14);
    chk("redir_c14_pc", instr_pc, 41);
    run_to_halt();

    do_reset();
    push_range(0, 9);
    go_to(10);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd40;
    push_range(40, 74);
    #1;
    chk("rs_mem_address", mem_address, 10);
    go_to(11);
    stall = 1'b0; redirect_valid = 1'b0;
    chk("rs_c11_valid", instr_valid, 0);
    go_to(12);
    chk("rs_c12_valid", instr_valid, 0);
    go_to(13);
    chk("rs_c13_pc", instr_pc, 40);
    chk("rs_c13_instr", instr, rom(8'd40));
    go_to(14);
    chk("rs_c14_pc", instr_pc, 41);
    run_to_halt();

    do_reset();
    push_range(0, 19);
    go_to(20);
    rst = 1'b1;
    go_to(21);
    rst = 1'b0;
    push_range(0, 114);
    chk("mrst_c21_valid", instr_valid, 0);
    go_to(22);
    chk("mrst_c22_valid", instr_valid, 0);
    go_to(23);
    chk("mrst_c23_valid", instr_valid, 1);
    chk("mrst_c23_pc", instr_pc, 0);
    run_to_halt();

    redirect_valid = 1'b1; redirect_pc = 8'd0;
    push_range(0, 114);
    #1;
    chk("hredir_t_halted", halted, 1);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("hredir_t1_halted", halted, 0);
    tick();
    chk("hredir_t2_valid", instr_valid, 0);
    tick();
    chk("hredir_t3_valid", instr_valid, 1);
    chk("hredir_t3_pc", instr_pc, 0);
    run_to_halt();

    redirect_valid = 1'b1; redirect_pc = 8'd113;
    push_range(113, 1);
    tick();
    redirect_valid = 1'b0;
    run_to_halt();
    chk("end_redir_pc", instr_pc, 113);

    redirect_valid = 1'b1; redirect_pc = 8'd250;
    push_range(250, 120);
    tick();
    redirect_valid = 1'b0;
    run_to_halt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter START_PC, default 8'd0, the address fetched first after reset.
REQ-002 SHALL have parameter END_PC, default 8'd113, the last program address; fetch halts after issuing it.
REQ-003 clk  input  1  the only clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  downstream cannot accept; hold the IF/ID outputs and replay the in-flight fetch.
REQ-006 redirect_valid  input  1  taken branch or jump from execute; flush and refetch.
REQ-007 redirect_pc  input  8  redirect target address.
REQ-008 mem_address  output  8  address to the instruction memory, which has 1-cycle registered read latency.
REQ-009 mem_data  input  32  memory read data, equal to rom[mem_address of the previous cycle].
REQ-010 instr  output  32  registered IF/ID instruction word.
REQ-011 instr_pc  output  8  address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc hold a live instruction.
REQ-013 halted  output  1  fetch has stopped at END_PC and the pipeline stage is drained.

Function
REQ-014 SHALL hold registers pc_q (next address), pc_d1 (address issued last cycle), issued_d1 (pc_d1 is live), IF/ID (instr, instr_pc, instr_valid), and state in {RUN, HALT}.
REQ-015 mem_address SHALL be combinational: pc_d1 when stall=1 and redirect_valid=0, otherwise pc_q.
REQ-016 RUN, no stall, no redirect: IF/ID SHALL load {mem_data, pc_d1, issued_d1}; pc_d1<=pc_q; issued_d1<=1; pc_q<=pc_q+1 (8-bit, 255 wraps to 0).
REQ-017 RUN, no stall, pc_q==END_PC: SHALL issue END_PC as in REQ-016, keep pc_q=END_PC, and go to HALT.
REQ-018 HALT, no stall, no redirect: IF/ID SHALL load as in REQ-016; issued_d1<=0; pc_q and pc_d1 held.
REQ-019 stall=1 with redirect_valid=0, in either state: all registers SHALL hold. Because of REQ-015, mem_data in the release cycle equals rom[pc_d1], so no word is lost or duplicated.
REQ-020 redirect_valid=1 SHALL take priority over stall and END_PC in any state: pc_q<=redirect_pc; issued_d1<=0; instr_valid<=0; state<=RUN.
REQ-021 Redirect latency: for a redirect in cycle t with no stall, instr_valid SHALL be 0 in t+1 and t+2, and 1 in t+3 with instr_pc=redirect_pc and instr=rom[redirect_pc].
REQ-022 Redirect to END_PC SHALL fetch END_PC once, then halt per REQ-017.
REQ-023 halted SHALL equal (state==HALT) && !issued_d1 && !instr_valid, as a combinational function of registers.
REQ-024 Throughput SHALL be one instruction per cycle in RUN with no stall; consecutive instr_pc values differ by 1 modulo 256.
REQ-025 instr and instr_pc SHALL change only on cycles where IF/ID loads.

Reset
REQ-026 While rst=1: pc_q=START_PC, pc_d1=0, issued_d1=0, instr=0, instr_pc=0, instr_valid=0, state=RUN, halted=0, mem_address=START_PC.
REQ-027 rst SHALL override stall and redirect_valid. Reset mid-fetch SHALL discard all in-flight and IF/ID contents.
REQ-028 First cycle after rst falls is cycle 0. instr_valid SHALL be 1 from cycle 2 with instr_pc=START_PC, absent stall and redirect.

Verification
REQ-029 Default parameters, no stall or redirect: instr_pc runs 0,1,2,...,113 on consecutive cycles starting at cycle 2. From cycle 116 onward: instr_valid=0, halted=1, mem_address=113.
REQ-030 Stall held for cycles 5-7 (instr_pc=3 in cycle 5): instr_pc=3 and instr stay unchanged through cycle 8; instr_pc=4 in cycle 9; no address skipped or repeated.
REQ-031 Redirect to 8'd40 in cycle 10: instr_valid=0 in cycles 11-12; cycle 13 shows instr_pc=40, instr=rom[40]; cycle 14 shows instr_pc=41.
REQ-032 Redirect and stall both high in cycle 10: behaviour identical to REQ-031.
REQ-033 END_PC=255, START_PC=254: instr_pc 254,255 then halt. Separately, redirect in HALT to 8'd0: halted falls next cycle; instr_pc=0 valid three cycles after the redirect.
REQ-034 rst pulsed for one cycle mid-run (cycle 20): instr_valid=0 in cycle 21; refetch restarts at START_PC with instr_valid=1, instr_pc=0 in cycle 23.
